prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Run controller that sequences the instruction-fetch program counter across the series of test programs issued by the bench.
- Converts the bench Start handshake into program-start loads at per-program base addresses.
- Resolves conditional relative branches against the current program's base address.
- Stops fetch on Halt and reports Done/AllDone plus a per-program cycle count.
- Sits between the bench/decoder and the PC register; drives the PC's load/enable controls.

Parameters:
A, 10, instruction-memory address width
NPROG, 3, number of programs in the series (1..4)
BASE0, 0, start address of program 0
BASE1, 160, start address of program 1
BASE2, 400, start address of program 2
BASE3, 0, start address of program 3 (unused when NPROG<4)
CW, 16, cycle counter width

Ports:
Clk  in  1  clock; all state changes on posedge
Reset  in  1  asynchronous, active-high reset
Start  in  1  bench request level; one program per high-then-low pulse
Halt  in  1  decoder: current instruction is the program-end halt
BranchRelEn  in  1  decoder: current instruction is a conditional branch
ALU_flag  in  1  ALU: branch condition met
Target  in  8  branch offset from current program base, unsigned
PcLoad  out  1  load PC with PcLoadVal this cycle
PcLoadVal  out  A  value to load
PcEnable  out  1  PC increments when high and PcLoad low
ProgIdx  out  2  index of current/last program
Busy  out  1  program loading or running
Done  out  1  current program halted; ack to bench
AllDone  out  1  sticky: last program halted and a further Start seen
CycleCount  out  CW  RUN cycles of current/last program

Behaviour:
- States: IDLE, ARMED, LOAD, RUN, DONE.
- Start edge detect: one flop start_r <= Start.
  - rise = Start & ~start_r; fall = ~Start & start_r.
  - start_r reset to 0.
- Reset (async) values:
  - state IDLE, ProgIdx 0, CycleCount 0, AllDone 0, start_r 0.
  - Resulting outputs: PcLoad 0, PcEnable 0, Busy 0, Done 0, PcLoadVal 0.
- Transitions:
  - IDLE: rise -> ARMED.
  - ARMED: fall -> LOAD. A rise cannot occur while in ARMED.
  - LOAD: exactly one cycle.
    - PcLoad=1, PcLoadVal=BASE[ProgIdx]; CycleCount <= 0.
    - -> RUN.
  - RUN: PcEnable=1; CycleCount += 1 per cycle, saturating at all-ones.
    - Halt=1 -> DONE; no PcLoad that cycle; the count for that cycle is included.
    - Otherwise, BranchRelEn & ALU_flag: PcLoad=1, PcLoadVal = (BASE[ProgIdx] + zero-extended Target) mod 2^A.
    - Halt takes priority over a branch in the same cycle.
    - Start edges are ignored in RUN; start_r still tracks Start.
  - DONE: Done=1, PcEnable=0, CycleCount held.
    - On rise with ProgIdx < NPROG-1: ProgIdx += 1, -> ARMED, Done drops next cycle.
    - On rise with ProgIdx == NPROG-1: AllDone <= 1, stay in DONE. Further Starts are ignored until Reset.
- Output decode:
  - PcLoad and PcLoadVal are combinational from state and inputs.
  - PcLoadVal = 0 whenever PcLoad = 0.
  - Busy = (LOAD | RUN). Done = (state==DONE). All other outputs are registered.
- Latency: fall of Start at edge k -> LOAD during cycle k+1 -> first PC increment enabled at cycle k+2.
- Reset mid-RUN: immediate return to IDLE. The program index restarts at 0.

Decomposition:
- Package prog_seq_pkg:
  - state enum (IDLE, ARMED, LOAD, RUN, DONE), 3-bit.
  - Default base-address constants and the BASE lookup function (index -> A-bit address).
- Sub-module start_edge_det: start_r flop with rise/fall outputs, async reset. Reused by any bench-facing handshake.
- Everything else stays in the top FSM.

Test Plan:
- Reset, then Start high 3 cycles, then low -> ARMED then LOAD; PcLoad=1, PcLoadVal=0; next cycle PcEnable=1, Busy=1.
- Program 1 (ProgIdx=1) running; BranchRelEn=1, ALU_flag=1, Target=0x25 -> PcLoad=1, PcLoadVal=197. With ALU_flag=0 -> PcLoad=0.
- Halt and a taken branch in the same cycle in RUN, 12 RUN cycles elapsed -> no PcLoad; Done=1 next cycle; CycleCount=12 and held; PcEnable=0.
- Three full Start/Halt sequences -> loads at 0, 160, 400; ProgIdx 0, 1, 2. Fourth Start rise -> AllDone=1, ProgIdx stays 2, no PcLoad.
- Start pulsed during RUN -> no state change; the next valid rise in DONE still advances normally.
- Async Reset asserted mid-RUN between clock edges -> outputs go to reset values immediately; a following Start loads BASE0=0.
- CW=4, run 20 cycles -> CycleCount saturates at 15.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and base-address table for the program sequencer.
// The FSM state encoding and the default program start addresses live here.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int BASE0_DEF = 0;
    localparam int BASE1_DEF = 160;
    localparam int BASE2_DEF = 400;
    localparam int BASE3_DEF = 0;

    // Wide result; callers truncate to their own address width.
    function automatic logic [31:0] base_lookup(input logic [1:0] idx,
                                                input int b0, input int b1,
                                                input int b2, input int b3);
        logic [31:0] r;
        case (idx)
            2'd0:    r = 32'(b0);
            2'd1:    r = 32'(b1);
            2'd2:    r = 32'(b2);
            default: r = 32'(b3);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/start_edge_det.sv
// One-flop level tracker producing single-cycle rise/fall strobes for a
// bench-facing handshake level.
module start_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: turns Start pulses into per-program PC loads, resolves
// base-relative branches, and stops fetch on Halt with a saturating cycle count.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int A     = 10,
    parameter int NPROG = 3,
    parameter int BASE0 = BASE0_DEF,
    parameter int BASE1 = BASE1_DEF,
    parameter int BASE2 = BASE2_DEF,
    parameter int BASE3 = BASE3_DEF,
    parameter int CW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          BranchRelEn,
    input  logic          ALU_flag,
    input  logic [7:0]    Target,
    output logic          PcLoad,
    output logic [A-1:0]  PcLoadVal,
    output logic          PcEnable,
    output logic [1:0]    ProgIdx,
    output logic          Busy,
    output logic          Done,
    output logic          AllDone,
    output logic [CW-1:0] CycleCount
);

    localparam logic [1:0] LAST_IDX = 2'(NPROG - 1);

    state_e         state_q, state_d;
    logic [1:0]     prog_idx_q, prog_idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           all_done_q, all_done_d;
    logic           start_rise, start_fall;
    logic [A-1:0]   base_addr;

    start_edge_det u_start_edge (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .level_i (Start),
        .rise_o  (start_rise),
        .fall_o  (start_fall)
    );

    assign base_addr = A'(base_lookup(prog_idx_q, BASE0, BASE1, BASE2, BASE3));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prog_idx_q <= 2'd0;
            cnt_q      <= '0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            cnt_q      <= cnt_d;
            all_done_q <= all_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prog_idx_d = prog_idx_q;
        cnt_d      = cnt_q;
        all_done_d = all_done_q;
        case (state_q)
            IDLE:  if (start_rise) state_d = ARMED;
            ARMED: if (start_fall) state_d = LOAD;
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Halt-cycle is counted, so the increment is unconditional here.
                if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                if (Halt) state_d = DONE;
            end
            DONE: begin
                // Once the last program is acknowledged, Starts are dead until Reset.
                if (start_rise && !all_done_q) begin
                    if (prog_idx_q == LAST_IDX) begin
                        all_done_d = 1'b1;
                    end else begin
                        prog_idx_d = prog_idx_q + 2'd1;
                        state_d    = ARMED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PcLoad    = 1'b0;
        PcLoadVal = '0;
        PcEnable  = 1'b0;
        Busy      = (state_q == LOAD) || (state_q == RUN);
        Done      = (state_q == DONE);
        case (state_q)
            LOAD: begin
                PcLoad    = 1'b1;
                PcLoadVal = base_addr;
            end
            RUN: begin
                PcEnable = 1'b1;
                if (!Halt && BranchRelEn && ALU_flag) begin
                    PcLoad    = 1'b1;
                    PcLoadVal = base_addr + A'(Target);
                end
            end
            default: ;
        endcase
    end

    assign ProgIdx    = prog_idx_q;
    assign AllDone    = all_done_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Table-driven bench for prog_sequencer with a scoreboard of expected outputs,
// plus a hand-written async-reset sequence; a CW=4 copy checks saturation.
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start, Halt, BranchRelEn, ALU_flag;
    logic [7:0]  Target;

    logic        PcLoad, PcEnable, Busy, Done, AllDone;
    logic [9:0]  PcLoadVal;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;

    logic        PcLoad4, PcEnable4, Busy4, Done4, AllDone4;
    logic [9:0]  PcLoadVal4;
    logic [1:0]  ProgIdx4;
    logic [3:0]  CycleCount4;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    prog_sequencer #(.A(10), .NPROG(3), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag), .Target(Target),
        .PcLoad(PcLoad), .PcLoadVal(PcLoadVal), .PcEnable(PcEnable),
        .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done), .AllDone(AllDone),
        .CycleCount(CycleCount)
    );

    prog_sequencer #(.A(10), .NPROG(3), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag), .Target(Target),
        .PcLoad(PcLoad4), .PcLoadVal(PcLoadVal4), .PcEnable(PcEnable4),
        .ProgIdx(ProgIdx4), .Busy(Busy4), .Done(Done4), .AllDone(AllDone4),
        .CycleCount(CycleCount4)
    );

    typedef struct {
        logic        start, halt, br, flag;
        logic [7:0]  tgt;
        logic        pcl;
        logic [9:0]  pcv;
        logic        pce, busy, done;
        logic [1:0]  idx;
        logic        alld;
        logic [15:0] cnt;
        int          row;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void add(input bit s, input bit h, input bit b, input bit f, input int tgt,
                                input bit pcl, input int pcv, input bit pce, input bit busy,
                                input bit done, input int idx, input bit alld, input int cnt);
        vec_t v;
        v.start = s; v.halt = h; v.br = b; v.flag = f; v.tgt = 8'(tgt);
        v.pcl = pcl; v.pcv = 10'(pcv); v.pce = pce; v.busy = busy; v.done = done;
        v.idx = 2'(idx); v.alld = alld; v.cnt = 16'(cnt); v.row = tbl.size();
        tbl.push_back(v);
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Compare DUT outputs against the scoreboard head on each falling edge.
    always @(negedge Clk) begin : sb_check
        vec_t e;
        logic [15:0] c4;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("row%0d", e.row),
                64'({PcLoad, PcLoadVal, PcEnable, Busy, Done, ProgIdx, AllDone, CycleCount}),
                64'({e.pcl, e.pcv, e.pce, e.busy, e.done, e.idx, e.alld, e.cnt}));
            c4 = (e.cnt > 16'd15) ? 16'd15 : e.cnt;
            chk($sformatf("row%0d_cw4", e.row), 64'(CycleCount4), 64'(c4));
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
        BranchRelEn = 1'b0; ALU_flag = 1'b0; Target = 8'd0;

        // Idle, then Start held for three cycles and released.
        add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
        for (int k = 0; k < 3; k++) add(1,0,0,0,0, 0,0,0,0,0, 0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
        add(0,0,0,0,0, 1,0,0,1,0, 0,0,0);
        // Program 0: Start pulse in RUN ignored, one taken branch, Halt+branch on cycle 12.
        for (int j = 1; j <= 11; j++)
            add(j == 3, 0, j == 6, j == 6, 3, j == 6, (j == 6) ? 3 : 0, 1,1,0, 0,0, j - 1);
        add(0,1,1,1,16, 0,0,1,1,0, 0,0,11);
        add(0,0,0,0,0, 0,0,0,0,1, 0,0,12);
        add(0,0,0,0,0, 0,0,0,0,1, 0,0,12);
        add(1,0,0,0,0, 0,0,0,0,1, 0,0,12);
        add(1,0,0,0,0, 0,0,0,0,0, 1,0,12);
        add(0,0,0,0,0, 0,0,0,0,0, 1,0,12);
        add(0,0,0,0,0, 1,160,0,1,0, 1,0,12);
        // Program 1: taken branch to 160+0x25, untaken branch, 20 RUN cycles.
        add(0,0,1,1,8'h25, 1,197,1,1,0, 1,0,0);
        add(0,0,1,0,8'h25, 0,0,1,1,0, 1,0,1);
        for (int j = 3; j <= 19; j++) add(0,0,0,0,0, 0,0,1,1,0, 1,0,j - 1);
        add(0,1,0,0,0, 0,0,1,1,0, 1,0,19);
        add(0,0,0,0,0, 0,0,0,0,1, 1,0,20);
        add(1,0,0,0,0, 0,0,0,0,1, 1,0,20);
        add(0,0,0,0,0, 0,0,0,0,0, 2,0,20);
        add(0,0,0,0,0, 1,400,0,1,0, 2,0,20);
        // Program 2: branches at maximum and zero offset.
        add(0,0,0,0,0, 0,0,1,1,0, 2,0,0);
        add(0,0,1,1,8'hFF, 1,655,1,1,0, 2,0,1);
        add(0,0,1,1,8'h00, 1,400,1,1,0, 2,0,2);
        add(0,0,0,0,0, 0,0,1,1,0, 2,0,3);
        add(0,1,0,0,0, 0,0,1,1,0, 2,0,4);
        add(0,0,0,0,0, 0,0,0,0,1, 2,0,5);
        // Start after the last program: AllDone, no load, further Starts ignored.
        add(1,0,1,1,5, 0,0,0,0,1, 2,0,5);
        add(0,0,0,0,0, 0,0,0,0,1, 2,1,5);
        add(1,0,0,0,0, 0,0,0,0,1, 2,1,5);
        add(0,0,0,0,0, 0,0,0,0,1, 2,1,5);
        add(0,0,0,0,0, 0,0,0,0,1, 2,1,5);

        #1;
        chk("reset_outputs",
            64'({PcLoad, PcLoadVal, PcEnable, Busy, Done, ProgIdx, AllDone, CycleCount}), 64'd0);
        #11 Reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            tick;
            Start = tbl[i].start; Halt = tbl[i].halt;
            BranchRelEn = tbl[i].br; ALU_flag = tbl[i].flag; Target = tbl[i].tgt;
            sb.push_back(tbl[i]);
        end
        tick;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        Start = 1'b0; Halt = 1'b0; BranchRelEn = 1'b0; ALU_flag = 1'b0; Target = 8'd0;

        // Reset clears sticky AllDone, then start a program and reset it mid-RUN.
        Reset = 1'b1;
        #2 Reset = 1'b0;
        chk("reset_clears_alldone", 64'({AllDone, ProgIdx}), 64'd0);
        tick; Start = 1'b1;
        tick; Start = 1'b0;
        tick; tick; tick; tick;
        #2;
        chk("midrun_busy_cnt", 64'({Busy, PcEnable, CycleCount}), 64'({1'b1, 1'b1, 16'd2}));
        Reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            64'({PcLoad, PcLoadVal, PcEnable, Busy, Done, ProgIdx, AllDone, CycleCount}), 64'd0);
        #1 Reset = 1'b0;
        tick; Start = 1'b1;
        tick; Start = 1'b0;
        tick;
        #3;
        chk("reload_base0", 64'({PcLoad, PcLoadVal, Busy, ProgIdx}),
            64'({1'b1, 10'd0, 1'b1, 2'd0}));
        tick;
        #3;
        chk("reload_run", 64'({PcLoad, PcEnable, Busy}), 64'({1'b0, 1'b1, 1'b1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
